// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
// The CSUM state is only entered when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_boot_loader_pkg;

    localparam int HDR_W = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: packs LE words into imem and holds the core until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CSUM;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t            state;
    state_t            state_nx;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   wcnt;
    logic [1:0]        lane;
    logic [23:0]       part;
    logic [7:0]        csum;
    logic [HDR_W-1:0]  hdr;
    logic              take;
    logic              last_word;
    logic              done_d;
    logic              err_d;
    logic              restart;

    assign in_ready  = (state != DONE) && (state != ERR);
    assign take      = in_valid && in_ready;
    assign hdr       = {in_data, len_lo};
    assign last_word = (lane == 2'd3) && ((wcnt + 1'b1) == n_words);
    assign restart   = reload && !in_ready;

    // Flags follow the state one cycle late so the last write lands first.
    assign done_d = (state == DONE) && (state_nx == DONE);
    assign err_d  = (state == ERR) && (state_nx == ERR);

    always_comb begin
        state_nx = state;
        unique case (state)
            LEN_LO: begin
                if (take) state_nx = LEN_HI;
            end
            LEN_HI: begin
                if (take) begin
                    if (hdr == '0)
                        state_nx = PAYLOAD_END;
                    else if (hdr > HDR_W'(DEPTH))
                        state_nx = ERR;
                    else
                        state_nx = DATA;
                end
            end
            DATA: begin
                if (take && last_word) state_nx = PAYLOAD_END;
            end
            CSUM: begin
                if (take) state_nx = (in_data == csum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (reload) state_nx = LEN_LO;
            end
            default: state_nx = LEN_LO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LEN_LO;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo     <= '0;
            n_words    <= '0;
            wcnt       <= '0;
            lane       <= '0;
            part       <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            done      <= done_d;
            error     <= err_d;
            core_hold <= !done_d;
            if (restart) begin
                wcnt <= '0;
                lane <= '0;
                csum <= '0;
            end
            if (take) begin
                unique case (state)
                    LEN_LO: len_lo <= in_data;
                    LEN_HI: begin
                        n_words <= hdr[ADDR_W:0];
                        wcnt    <= '0;
                        lane    <= '0;
                        csum    <= '0;
                    end
                    DATA: begin
                        csum <= csum ^ in_data;
                        lane <= lane + 2'd1;
                        part <= {in_data, part[23:8]};
                        if (lane == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= wcnt[ADDR_W-1:0];
                            imem_wdata <= {in_data, part};
                            wcnt       <= wcnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a frame-level model.
// Follows IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    imem_boot_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  frame[$];
    logic [31:0] exp_w[$];
    bit          exp_err;
    logic [5:0]  got_a[$];
    logic [31:0] got_d[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            got_a.push_back(imem_waddr);
            got_d.push_back(imem_wdata);
            check("hold_during_we", {31'd0, core_hold}, 32'd1);
        end
    end

    function automatic logic [7:0] payload_xor();
        logic [7:0] x = 8'h00;
        for (int i = 2; i < frame.size(); i++) x ^= frame[i];
        return x;
    endfunction

    // Appends the trailing checksum in the checksum build; bad corrupts it.
    task automatic add_csum(input bit bad);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = payload_xor();
        if (bad) x ^= 8'($urandom_range(1, 255));
        frame.push_back(x);
`else
        if (bad) frame = frame;
`endif
    endtask

    task automatic build_frame(input int n, input bit bad);
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        if (n <= 64) begin
            for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
            add_csum(bad);
        end
    endtask

    // Expected writes and outcome straight from the framing rules.
    task automatic model();
        int n;
        exp_w.delete();
        n = {frame[1], frame[0]};
        exp_err = 1'b0;
        if (n > 64) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_w.push_back({frame[2+4*i+3], frame[2+4*i+2],
                             frame[2+4*i+1], frame[2+4*i]});
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = 0; i < 4 * n; i++) x ^= frame[2+i];
            exp_err = (frame[2+4*n] != x);
        end
`endif
    endtask

    // Entered and left at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit rl);
        bit ok = 1'b0;
        bit rdy;
        in_valid = 1'b0;
        reload   = rl;
        repeat (gap) @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input string tag, input int gmin, input int gmax,
                             input bit rl);
        got_a.delete();
        got_d.delete();
        model();
        for (int i = 0; i < frame.size(); i++)
            send_byte(frame[i], $urandom_range(gmin, gmax), rl);
        check({tag, "_done_early"}, {31'd0, done}, 32'd0);
        check({tag, "_err_early"}, {31'd0, error}, 32'd0);
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, {31'd0, !exp_err});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_hold"}, {31'd0, core_hold}, {31'd0, exp_err});
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we_low"}, {31'd0, imem_we}, 32'd0);
        @(negedge clk);
        check({tag, "_nwr"}, got_d.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_d.size(); i++) begin
            check({tag, "_addr"}, {26'd0, got_a[i]}, i);
            check({tag, "_data"}, got_d[i], exp_w[i]);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
        check("rl_ready", {31'd0, in_ready}, 32'd1);
        check("rl_done", {31'd0, done}, 32'd0);
        check("rl_error", {31'd0, error}, 32'd0);
        check("rl_hold", {31'd0, core_hold}, 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {26'd0, imem_waddr}, 32'd0);
        check("rst_data", imem_wdata, 32'd0);
        check("rst_hold", {31'd0, core_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_csum(1'b0);
        run_frame("two_words", 0, 0, 1'b0);
        check("w0_lit", got_d.size() > 0 ? got_d[0] : 32'd0, 32'h12345678);
        check("w1_lit", got_d.size() > 1 ? got_d[1] : 32'd0, 32'hDEADBEEF);
        do_reload();

        frame = '{8'h41, 8'h00};
        run_frame("too_long", 0, 1, 1'b0);
        check("too_long_err", {31'd0, error}, 32'd1);
        do_reload();

        frame = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        add_csum(1'b0);
        run_frame("gaps", 3, 3, 1'b1);
        check("gaps_lit", got_d.size() > 0 ? got_d[0] : 32'd0, 32'h04030201);
        do_reload();

        got_a.delete();
        got_d.delete();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hAA, 1, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_we", {31'd0, imem_we}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_hold", {31'd0, core_hold}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_nwr", got_d.size(), 32'd0);
        build_frame(1, 1'b0);
        run_frame("after_rst", 0, 1, 1'b0);
        do_reload();

        frame = '{8'h00, 8'h00};
        add_csum(1'b0);
        run_frame("empty", 0, 0, 1'b0);
        do_reload();

`ifdef IMEM_LOADER_CHECKSUM_EN
        frame = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        run_frame("csum_ok", 0, 0, 1'b0);
        do_reload();
        frame = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame("csum_bad", 0, 0, 1'b0);
        check("csum_bad_err", {31'd0, error}, 32'd1);
        do_reload();
`endif

        for (int k = 0; k < 25; k++) begin
            int r;
            int n;
            r = $urandom_range(0, 9);
            if (r == 0)      n = $urandom_range(65, 65535);
            else if (r == 1) n = 64;
            else             n = $urandom_range(1, 6);
            build_frame(n, $urandom_range(0, 4) == 0);
            run_frame("rand", 0, 2, 1'b0);
            do_reload();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
